// File: rtl/bias_stream_seq_pkg.sv
// rtl/bias_stream_seq_pkg.sv - shared sizes, FSM encoding and address-width helper for bias streamers
// Contents:
//   coeff_width      bias/weight coefficient width
//   kern_s_k_N       per-layer output-channel counts (feed MEM_SIZE)
//   seq_state_t      2-bit sequencer state encoding
//   addr_width()     ROM address width, never below 1 bit
package bias_stream_seq_pkg;

    localparam int coeff_width = 16;

    localparam int kern_s_k_0 = 16;
    localparam int kern_s_k_1 = 32;
    localparam int kern_s_k_2 = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // A one-word ROM still needs a 1-bit address bus.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bias_stream_seq_if.sv
// rtl/bias_stream_seq_if.sv - ROM read port and ap_fifo output stream bundle
// Signals:
//   rom_address, rom_ce   sequencer -> ROM read request
//   rom_q                 ROM -> sequencer, valid the cycle after rom_ce
//   output_V_din/_write   sequencer -> FIFO write
//   output_V_full_n       FIFO -> sequencer, not-full
// Modports: master = sequencer side, slave = ROM/FIFO side.
interface bias_stream_seq_if #(
    parameter int ADDR_W     = 4,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_W-1:0]     rom_address;
    logic                  rom_ce;
    logic [DATA_WIDTH-1:0] rom_q;
    logic [DATA_WIDTH-1:0] output_V_din;
    logic                  output_V_full_n;
    logic                  output_V_write;

    modport master (
        output rom_address, rom_ce, output_V_din, output_V_write,
        input  rom_q, output_V_full_n
    );

    modport slave (
        input  rom_address, rom_ce, output_V_din, output_V_write,
        output rom_q, output_V_full_n
    );
endinterface

// File: rtl/bias_stream_seq_skid_buf.sv
// rtl/bias_stream_seq_skid_buf.sv - bias_skid_buf: 2-entry FIFO absorbing ROM read latency
// Ports:
//   clk, rst        clock, async active-high reset
//   push, push_data write a word (caller guarantees count < 2)
//   pop             drop the head word (caller guarantees count > 0)
//   count           words held, 0..2
//   head            oldest word, 0 when empty
module bias_skid_buf #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] head
);
    logic [DATA_WIDTH-1:0] mem [2];
    logic                  rd_ptr;
    logic                  wr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // Simultaneous push and pop leave the count as is; the pointers keep order.
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = (count != 2'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/bias_stream_seq.sv
// rtl/bias_stream_seq.sv - replays a bias ROM NUM_PASSES times into an ap_fifo output stream
// Ports:
//   ap_clk, ap_rst   clock, async active-high reset
//   ap_start         run request, sampled in IDLE only
//   ap_done          high for the single DONE cycle
//   ap_idle          high while IDLE
//   bus (master)     ROM read port + output stream
// Option: BIAS_STREAM_SEQ_LOOP_EN makes the stream repeat forever after a start.
module bias_stream_seq
    import bias_stream_seq_pkg::*;
#(
    parameter int MEM_SIZE   = kern_s_k_0,
    parameter int DATA_WIDTH = coeff_width,
    parameter int NUM_PASSES = 4
) (
    input  logic ap_clk,
    input  logic ap_rst,
    input  logic ap_start,
    output logic ap_done,
    output logic ap_idle,
    bias_stream_seq_if.master bus
);
    localparam int ADDR_W = addr_width(MEM_SIZE);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE - 1);
`ifndef BIAS_STREAM_SEQ_LOOP_EN
    localparam int PASS_W = $clog2(NUM_PASSES + 1);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);
    logic [PASS_W-1:0] pass;
`endif

    seq_state_t            state;
    logic [ADDR_W-1:0]     addr;
    logic                  in_flight;
    logic [1:0]            skid_count;
    logic [DATA_WIDTH-1:0] skid_head;
    logic [2:0]            occupancy;
    logic                  issue;
    logic                  write;

    // Words already buffered plus the one the ROM is returning: never let
    // this reach 3, whatever the FIFO does, so the skid cannot overflow.
    assign occupancy = {1'b0, skid_count} + {2'b00, in_flight};
    assign issue     = (state == ST_RUN) && (occupancy < 3'd2);
    assign write     = (skid_count != 2'd0) && bus.output_V_full_n;

    bias_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk       (ap_clk),
        .rst       (ap_rst),
        .push      (in_flight),
        .push_data (bus.rom_q),
        .pop       (write),
        .count     (skid_count),
        .head      (skid_head)
    );

    assign bus.rom_ce         = issue;
    assign bus.rom_address    = addr;
    assign bus.output_V_din   = skid_head;
    assign bus.output_V_write = write;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state     <= ST_IDLE;
            addr      <= '0;
            in_flight <= 1'b0;
            ap_done   <= 1'b0;
            ap_idle   <= 1'b1;
`ifndef BIAS_STREAM_SEQ_LOOP_EN
            pass      <= '0;
`endif
        end else begin
            // rom_q for this read is valid next cycle and is pushed on the edge after.
            in_flight <= issue;

            if (issue) begin
                if (addr == LAST_ADDR) begin
                    addr <= '0;
`ifndef BIAS_STREAM_SEQ_LOOP_EN
                    pass <= pass + PASS_W'(1);
`endif
                end else begin
                    addr <= addr + ADDR_W'(1);
                end
            end

            case (state)
                ST_IDLE: begin
                    if (ap_start) begin
                        state   <= ST_RUN;
                        ap_idle <= 1'b0;
                        addr    <= '0;
`ifndef BIAS_STREAM_SEQ_LOOP_EN
                        pass    <= '0;
`endif
                    end
                end
                ST_RUN: begin
`ifndef BIAS_STREAM_SEQ_LOOP_EN
                    if (issue && (addr == LAST_ADDR) && (pass == LAST_PASS)) begin
                        state <= ST_DRAIN;
                    end
`endif
                end
                ST_DRAIN: begin
                    if ((skid_count == 2'd0) && !in_flight) begin
                        state   <= ST_DONE;
                        ap_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    ap_done <= 1'b0;
                    ap_idle <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
